// File: rtl/jp_poller.sv
// jp_poller: autonomous NES joypad scanner.
// Every POLL_INTERVAL cycles (when enabled) it pulses the shared latch, clocks
// both pads eight times and captures 9 bits per pad (8 buttons + presence bit).
// Button bytes are committed once per frame with a one-cycle valid strobe.
//
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous active-low reset
//   enable_in         polling allowed (looked at only while idle)
//   jp_data1_in/2_in  raw serial data from pads (pressed = 0, unplugged = 0)
//   jp_latch_out      shared latch, active-high
//   jp_clk1_out/2_out pad shift clocks, idle low, identical waveforms
//   pad*_buttons_out  button bytes, 1 = pressed (A,B,Sel,Start,Up,Down,Left,Right)
//   pad*_present_out  pad detected on last completed frame
//   valid_out         one-cycle pulse when outputs update
//   changed_out       pulses with valid_out when either button byte changed
module jp_poller #(
  parameter int HALF_PERIOD   = 150,
  parameter int POLL_INTERVAL = 416667
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       jp_data1_in,
  input  logic       jp_data2_in,
  output logic       jp_latch_out,
  output logic       jp_clk1_out,
  output logic       jp_clk2_out,
  output logic [7:0] pad1_buttons_out,
  output logic [7:0] pad2_buttons_out,
  output logic       pad1_present_out,
  output logic       pad2_present_out,
  output logic       valid_out,
  output logic       changed_out
);

  localparam int HW = $clog2(2 * HALF_PERIOD);
  localparam int PW = $clog2(POLL_INTERVAL);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_PERIOD - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_INTERVAL - 1);
  localparam logic [3:0]    LAST_BIT   = 4'd8;

  typedef enum logic [2:0] {IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, DONE} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hp_cnt_q, hp_cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    shift1_q, shift1_d, shift2_q, shift2_d;
  logic          data1_meta_q, data1_meta_d, data1_sync_q, data1_sync_d;
  logic          data2_meta_q, data2_meta_d, data2_sync_q, data2_sync_d;
  logic          latch_q, latch_d, clk_q, clk_d;
  logic [7:0]    btn1_q, btn1_d, btn2_q, btn2_d;
  logic          present1_q, present1_d, present2_q, present2_d;
  logic          valid_q, valid_d, changed_q, changed_d;
  logic          tick;
  logic          sample;

  // Input synchronizers and free-running poll timer.
  always_comb begin
    data1_meta_d = jp_data1_in;
    data1_sync_d = data1_meta_q;
    data2_meta_d = jp_data2_in;
    data2_sync_d = data2_meta_q;
    tick         = (poll_cnt_q == POLL_LAST);
    poll_cnt_d   = tick ? '0 : poll_cnt_q + 1'b1;
  end

  // State register plus the frame datapath it sequences.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      hp_cnt_q     <= '0;
      poll_cnt_q   <= '0;
      idx_q        <= '0;
      shift1_q     <= '0;
      shift2_q     <= '0;
      data1_meta_q <= 1'b0;
      data1_sync_q <= 1'b0;
      data2_meta_q <= 1'b0;
      data2_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      idx_q        <= idx_d;
      shift1_q     <= shift1_d;
      shift2_q     <= shift2_d;
      data1_meta_q <= data1_meta_d;
      data1_sync_q <= data1_sync_d;
      data2_meta_q <= data2_meta_d;
      data2_sync_q <= data2_sync_d;
    end
  end

  // Next-state logic. A tick arriving outside IDLE is simply lost.
  // Samples happen on the last cycle of SETTLE and of each CLK_LO, so bit 0
  // comes from the latch itself and bits 1..8 follow each rising clock.
  always_comb begin
    state_d  = state_q;
    hp_cnt_d = hp_cnt_q + 1'b1;
    idx_d    = idx_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    sample   = 1'b0;
    case (state_q)
      IDLE: begin
        hp_cnt_d = '0;
        if (tick && enable_in) begin
          state_d = LATCH;
          idx_d   = '0;
        end
      end
      LATCH: begin
        if (hp_cnt_q == LATCH_LAST) begin
          state_d  = SETTLE;
          hp_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (hp_cnt_q == HALF_LAST) begin
          sample   = 1'b1;
          state_d  = CLK_HI;
          hp_cnt_d = '0;
        end
      end
      CLK_HI: begin
        if (hp_cnt_q == HALF_LAST) begin
          idx_d    = idx_q + 4'd1;
          state_d  = CLK_LO;
          hp_cnt_d = '0;
        end
      end
      CLK_LO: begin
        if (hp_cnt_q == HALF_LAST) begin
          sample   = 1'b1;
          state_d  = (idx_q == LAST_BIT) ? DONE : CLK_HI;
          hp_cnt_d = '0;
        end
      end
      DONE: begin
        state_d  = IDLE;
        hp_cnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        hp_cnt_d = '0;
      end
    endcase
    // Button bits arrive active-low; the trailing presence bit is kept raw.
    if (sample) begin
      shift1_d[idx_q] = (idx_q == LAST_BIT) ? data1_sync_q : ~data1_sync_q;
      shift2_d[idx_q] = (idx_q == LAST_BIT) ? data2_sync_q : ~data2_sync_q;
    end
  end

  // Output logic. Pin drives follow the next state so they line up with the
  // registered state; button results are committed while in DONE.
  always_comb begin
    latch_d    = (state_d == LATCH);
    clk_d      = (state_d == CLK_HI);
    btn1_d     = btn1_q;
    btn2_d     = btn2_q;
    present1_d = present1_q;
    present2_d = present2_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;
    if (state_q == DONE) begin
      present1_d = shift1_q[8];
      present2_d = shift2_q[8];
      btn1_d     = shift1_q[8] ? shift1_q[7:0] : 8'h00;
      btn2_d     = shift2_q[8] ? shift2_q[7:0] : 8'h00;
      valid_d    = 1'b1;
      changed_d  = (btn1_d != btn1_q) || (btn2_d != btn2_q);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      latch_q    <= 1'b0;
      clk_q      <= 1'b0;
      btn1_q     <= 8'h00;
      btn2_q     <= 8'h00;
      present1_q <= 1'b0;
      present2_q <= 1'b0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      clk_q      <= clk_d;
      btn1_q     <= btn1_d;
      btn2_q     <= btn2_d;
      present1_q <= present1_d;
      present2_q <= present2_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
    end
  end

  assign jp_latch_out     = latch_q;
  assign jp_clk1_out      = clk_q;
  assign jp_clk2_out      = clk_q;
  assign pad1_buttons_out = btn1_q;
  assign pad2_buttons_out = btn2_q;
  assign pad1_present_out = present1_q;
  assign pad2_present_out = present2_q;
  assign valid_out        = valid_q;
  assign changed_out      = changed_q;

endmodule
